// File: rtl/instr_ram_pkg.sv
// Shared types and byte codes for the instruction RAM sequencing controller.
package instr_ram_pkg;

    typedef enum logic [1:0] {
        MODE_RUN  = 2'd0,
        MODE_LOAD = 2'd1,
        MODE_STEP = 2'd2,
        MODE_IDLE = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_STEP = 2'd3
    } state_e;

    localparam logic [7:0] DELIM_BYTE = 8'h24;
    localparam logic [7:0] IDLE_BYTE  = 8'h00;

endpackage

// File: rtl/btn_edge_detect.sv
// Front-panel button rising-edge detector; a single-cycle pulse follows each press.
// Define DEBUG_SYNC_EN to add a 2-flop synchronizer in front of the edge detector.
module btn_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_pulse
);

    logic w_btn;
    logic r_sample;
    logic r_sample_d;

`ifdef DEBUG_SYNC_EN
    logic [1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], i_btn};
        end
    end

    assign w_btn = r_sync[1];
`else
    assign w_btn = i_btn;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sample   <= 1'b0;
            r_sample_d <= 1'b0;
        end else begin
            r_sample   <= w_btn;
            r_sample_d <= r_sample;
        end
    end

    assign o_pulse = r_sample & ~r_sample_d;

endmodule

// File: rtl/instr_ram_ctrl.sv
// Instruction RAM controller: UART byte stream -> RAM writes, RUN/STEP read address sequencing.
// Define DEBUG_SYNC_EN to synchronize debug_btn (two extra cycles of step latency).
module instr_ram_ctrl
    import instr_ram_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int MAX_ADDRESS = 255,
    parameter int RUN_DIV     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            mode,
    input  logic                  debug_btn,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_valid,
    output logic                  ram_we,
    output logic [DATA_WIDTH-1:0] ram_waddr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic [DATA_WIDTH-1:0] ram_raddr,
    output logic [DATA_WIDTH:0]   instr_count,
    output logic                  rd_valid,
    output logic                  done,
    output logic                  overflow
);

    localparam int CW    = DATA_WIDTH + 1;
    localparam int DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;

    state_e r_state, w_state_next;
    logic   w_enter_load, w_enter_read, w_in_read;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = ST_IDLE;
        case (mode)
            MODE_RUN:  w_state_next = ST_RUN;
            MODE_LOAD: w_state_next = ST_LOAD;
            MODE_STEP: w_state_next = ST_STEP;
            default:   w_state_next = ST_IDLE;
        endcase
        w_enter_load = (w_state_next == ST_LOAD) && (r_state != ST_LOAD);
        w_enter_read = ((w_state_next == ST_RUN) || (w_state_next == ST_STEP))
                       && (r_state != w_state_next);
        w_in_read    = (r_state == ST_RUN) || (r_state == ST_STEP) || w_enter_read;
    end

    // ---------------- load path ----------------
    logic                  r_we;
    logic [DATA_WIDTH-1:0] r_waddr, r_wdata, r_pending;
    logic                  r_pending_vld;
    logic [CW-1:0]         r_instr_count;
    logic                  r_overflow;
    logic                  w_rx_data, w_rx_delim, w_full;

    assign w_rx_data  = rx_valid && (r_state == ST_LOAD)
                        && (rx_data != DATA_WIDTH'(IDLE_BYTE))
                        && (rx_data != DATA_WIDTH'(DELIM_BYTE));
    assign w_rx_delim = rx_valid && (r_state == ST_LOAD) && r_pending_vld
                        && (rx_data == DATA_WIDTH'(DELIM_BYTE));
    assign w_full     = (r_instr_count == CW'(MAX_ADDRESS + 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we          <= 1'b0;
            r_waddr       <= '0;
            r_wdata       <= '0;
            r_pending     <= '0;
            r_pending_vld <= 1'b0;
            r_instr_count <= '0;
            r_overflow    <= 1'b0;
        end else begin
            r_we <= 1'b0;
            // Address advances after the write pulse so the pulse carries the old address.
            if (r_we) begin
                r_waddr <= r_waddr + DATA_WIDTH'(1);
            end
            if (w_enter_load) begin
                r_waddr       <= '0;
                r_instr_count <= '0;
                r_overflow    <= 1'b0;
                r_pending_vld <= 1'b0;
            end else if (w_rx_data) begin
                r_pending     <= rx_data;
                r_pending_vld <= 1'b1;
            end else if (w_rx_delim) begin
                r_pending_vld <= 1'b0;
                if (w_full) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_we          <= 1'b1;
                    r_wdata       <= r_pending;
                    r_instr_count <= r_instr_count + CW'(1);
                end
            end
        end
    end

    // ---------------- read path ----------------
    logic                  w_step_pulse;
    logic [DATA_WIDTH-1:0] r_raddr, w_raddr_next;
    logic [DIV_W-1:0]      r_div, w_div_next;
    logic                  r_rd_valid, r_done;
    logic [CW-1:0]         w_last;
    logic                  w_empty, w_at_last, w_done_next;

    btn_edge_detect u_btn_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_btn   (debug_btn),
        .o_pulse (w_step_pulse)
    );

    always_comb begin
        w_empty      = (r_instr_count == '0);
        w_last       = r_instr_count - CW'(1);
        w_at_last    = ({1'b0, r_raddr} >= w_last);
        w_raddr_next = r_raddr;
        w_div_next   = r_div;
        if (w_enter_read) begin
            w_raddr_next = '0;
            w_div_next   = '0;
        end else if (r_state == ST_RUN) begin
            if (w_empty) begin
                w_raddr_next = '0;
            end else if (r_div == DIV_W'(RUN_DIV - 1)) begin
                w_div_next = '0;
                if (!w_at_last) begin
                    w_raddr_next = r_raddr + DATA_WIDTH'(1);
                end
            end else begin
                w_div_next = r_div + DIV_W'(1);
            end
        end else if (r_state == ST_STEP) begin
            if (w_step_pulse && !w_empty && !w_at_last) begin
                w_raddr_next = r_raddr + DATA_WIDTH'(1);
            end
        end
        // done is computed on the next address so it lines up with ram_raddr.
        w_done_next = w_empty || ({1'b0, w_raddr_next} >= w_last);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_raddr    <= '0;
            r_div      <= '0;
            r_rd_valid <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_raddr <= w_raddr_next;
            r_div   <= w_div_next;
            if (w_in_read) begin
                r_rd_valid <= !w_empty;
                r_done     <= w_done_next;
            end
        end
    end

    assign ram_we      = r_we;
    assign ram_waddr   = r_waddr;
    assign ram_wdata   = r_wdata;
    assign ram_raddr   = r_raddr;
    assign instr_count = r_instr_count;
    assign rd_valid    = r_rd_valid;
    assign done        = r_done;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_instr_ram_ctrl.sv
// Directed bench for instr_ram_ctrl; a second instance with MAX_ADDRESS=3 covers overflow.
module tb_instr_ram_ctrl;
    import instr_ram_pkg::*;

`ifdef DEBUG_SYNC_EN
    localparam int STEP_LAT = 3;
`else
    localparam int STEP_LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] mode = 2'd3;
    logic       debug_btn = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;

    logic       ram_we, rd_valid, done, overflow;
    logic [7:0] ram_waddr, ram_wdata, ram_raddr;
    logic [8:0] instr_count;

    logic       ram_we_s, rd_valid_s, done_s, overflow_s;
    logic [7:0] ram_waddr_s, ram_wdata_s, ram_raddr_s;
    logic [8:0] instr_count_s;

    int checks = 0;
    int failures = 0;
    int we_cnt = 0;
    int we_cnt_s = 0;

    logic       cap_we;
    logic [7:0] cap_waddr, cap_wdata;

    instr_ram_ctrl #(.DATA_WIDTH(8), .MAX_ADDRESS(255), .RUN_DIV(1)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .debug_btn(debug_btn),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
        .ram_raddr(ram_raddr), .instr_count(instr_count),
        .rd_valid(rd_valid), .done(done), .overflow(overflow)
    );

    instr_ram_ctrl #(.DATA_WIDTH(8), .MAX_ADDRESS(3), .RUN_DIV(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .mode(mode), .debug_btn(debug_btn),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .ram_we(ram_we_s), .ram_waddr(ram_waddr_s), .ram_wdata(ram_wdata_s),
        .ram_raddr(ram_raddr_s), .instr_count(instr_count_s),
        .rd_valid(rd_valid_s), .done(done_s), .overflow(overflow_s)
    );

    always #10 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we)   we_cnt   <= we_cnt + 1;
        if (ram_we_s) we_cnt_s <= we_cnt_s + 1;
    end

    // Single-strobe byte, data held 4 cycles; captures write port just after the strobe edge.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid  = 1'b0;
        cap_we    = ram_we;
        cap_waddr = ram_waddr;
        cap_wdata = ram_wdata;
        repeat (3) @(negedge clk);
    endtask

    task automatic set_mode(input logic [1:0] m);
        @(negedge clk);
        mode = m;
        @(negedge clk);
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if ({ram_we, ram_waddr, ram_wdata, ram_raddr, instr_count, rd_valid, done, overflow} !== 36'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %0h expected 0",
                     {ram_we, ram_waddr, ram_wdata, ram_raddr, instr_count, rd_valid, done, overflow});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        $display("test_reset done");
    endtask

    task automatic test_last_wins;
        int base;
        set_mode(2'd1);
        base = we_cnt;
        send_byte(8'h4A);
        checks++;
        if (cap_we !== 1'b0) begin failures++; $display("FAIL lw_data_no_write: got %0b expected 0", cap_we); end
        send_byte(8'h4B);
        send_byte(8'h24);
        checks++;
        if ({cap_we, cap_waddr, cap_wdata} !== {1'b1, 8'h00, 8'h4B}) begin
            failures++;
            $display("FAIL lw_commit: got we=%0b addr=%0h data=%0h expected we=1 addr=0 data=4b", cap_we, cap_waddr, cap_wdata);
        end
        send_byte(8'h24);
        checks++;
        if (cap_we !== 1'b0) begin failures++; $display("FAIL lw_second_delim: got %0b expected 0", cap_we); end
        checks++;
        if (we_cnt - base != 1) begin failures++; $display("FAIL lw_pulses: got %0d expected 1", we_cnt - base); end
        checks++;
        if (instr_count !== 9'd1) begin failures++; $display("FAIL lw_count: got %0d expected 1", instr_count); end
        $display("test_last_wins count=%0d", instr_count);
    endtask

    task automatic test_load4;
        logic [7:0] bytes [8] = '{8'h4A, 8'h24, 8'h4B, 8'h24, 8'h4C, 8'h24, 8'h4D, 8'h24};
        int base;
        set_mode(2'd3);
        set_mode(2'd1);
        checks++;
        if (instr_count !== 9'd0) begin failures++; $display("FAIL l4_entry_clear: got %0d expected 0", instr_count); end
        base = we_cnt;
        for (int i = 0; i < 8; i++) begin
            send_byte(bytes[i]);
            checks++;
            if (i % 2 == 1) begin
                if ({cap_we, cap_waddr, cap_wdata} !== {1'b1, 8'(i / 2), bytes[i-1]}) begin
                    failures++;
                    $display("FAIL l4_write%0d: got we=%0b addr=%0h data=%0h expected we=1 addr=%0h data=%0h",
                             i / 2, cap_we, cap_waddr, cap_wdata, i / 2, bytes[i-1]);
                end
            end else if (cap_we !== 1'b0) begin
                failures++;
                $display("FAIL l4_nowrite%0d: got %0b expected 0", i, cap_we);
            end
            $display("load byte %0h we=%0b addr=%0h data=%0h", bytes[i], cap_we, cap_waddr, cap_wdata);
        end
        checks++;
        if (we_cnt - base != 4) begin failures++; $display("FAIL l4_pulses: got %0d expected 4", we_cnt - base); end
        checks++;
        if (instr_count !== 9'd4) begin failures++; $display("FAIL l4_count: got %0d expected 4", instr_count); end
    endtask

    task automatic test_run;
        logic [7:0] exp_a [6] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd3, 8'd3};
        logic       exp_d [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        set_mode(2'd0);
        for (int k = 0; k < 6; k++) begin
            checks++;
            if ({ram_raddr, done, rd_valid} !== {exp_a[k], exp_d[k], 1'b1}) begin
                failures++;
                $display("FAIL run_cycle%0d: got raddr=%0d done=%0b rv=%0b expected raddr=%0d done=%0b rv=1",
                         k, ram_raddr, done, rd_valid, exp_a[k], exp_d[k]);
            end
            $display("run cycle %0d raddr=%0d done=%0b", k, ram_raddr, done);
            @(negedge clk);
        end
    endtask

    task automatic test_step;
        logic [7:0] exp_a [6] = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd3, 8'd3};
        logic       exp_d [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [7:0] prev;
        set_mode(2'd3);
        checks++;
        if ({ram_raddr, done} !== {8'd3, 1'b1}) begin
            failures++;
            $display("FAIL idle_hold: got raddr=%0d done=%0b expected raddr=3 done=1", ram_raddr, done);
        end
        set_mode(2'd2);
        checks++;
        if ({ram_raddr, done, rd_valid} !== {8'd0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL step_entry: got raddr=%0d done=%0b rv=%0b expected 0 0 1", ram_raddr, done, rd_valid);
        end
        for (int p = 0; p < 6; p++) begin
            prev = ram_raddr;
            @(negedge clk);
            debug_btn = 1'b1;
            @(negedge clk);
            debug_btn = 1'b0;
            checks++;
            if (ram_raddr !== prev) begin
                failures++;
                $display("FAIL step_early%0d: got %0d expected %0d", p, ram_raddr, prev);
            end
            repeat (STEP_LAT) @(negedge clk);
            checks++;
            if ({ram_raddr, done} !== {exp_a[p], exp_d[p]}) begin
                failures++;
                $display("FAIL step_press%0d: got raddr=%0d done=%0b expected raddr=%0d done=%0b",
                         p, ram_raddr, done, exp_a[p], exp_d[p]);
            end
            $display("step press %0d raddr=%0d done=%0b", p, ram_raddr, done);
        end
        set_mode(2'd3);
        set_mode(2'd2);
        @(negedge clk);
        debug_btn = 1'b1;
        repeat (10) @(negedge clk);
        debug_btn = 1'b0;
        repeat (STEP_LAT + 2) @(negedge clk);
        checks++;
        if (ram_raddr !== 8'd1) begin failures++; $display("FAIL step_held: got %0d expected 1", ram_raddr); end
        $display("step held raddr=%0d", ram_raddr);
    endtask

    task automatic test_overflow;
        int base_s;
        set_mode(2'd3);
        set_mode(2'd1);
        base_s = we_cnt_s;
        for (int i = 0; i < 5; i++) begin
            send_byte(8'h11 + 8'(i));
            send_byte(8'h24);
            $display("commit %0d small count=%0d ovf=%0b", i, instr_count_s, overflow_s);
        end
        checks++;
        if (we_cnt_s - base_s != 4) begin failures++; $display("FAIL ovf_pulses: got %0d expected 4", we_cnt_s - base_s); end
        checks++;
        if ({instr_count_s, overflow_s} !== {9'd4, 1'b1}) begin
            failures++;
            $display("FAIL ovf_small: got count=%0d ovf=%0b expected count=4 ovf=1", instr_count_s, overflow_s);
        end
        checks++;
        if ({instr_count, overflow} !== {9'd5, 1'b0}) begin
            failures++;
            $display("FAIL ovf_large: got count=%0d ovf=%0b expected count=5 ovf=0", instr_count, overflow);
        end
        set_mode(2'd3);
        set_mode(2'd1);
        checks++;
        if ({instr_count_s, overflow_s} !== {9'd0, 1'b0}) begin
            failures++;
            $display("FAIL ovf_reload_clear: got count=%0d ovf=%0b expected 0 0", instr_count_s, overflow_s);
        end
    endtask

    task automatic test_async_reset;
        int base;
        send_byte(8'h31);
        send_byte(8'h24);
        checks++;
        if (instr_count !== 9'd1) begin failures++; $display("FAIL ar_precount: got %0d expected 1", instr_count); end
        send_byte(8'h4A);
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({ram_we, ram_waddr, ram_wdata, ram_raddr, instr_count, rd_valid, done, overflow} !== 36'd0) begin
            failures++;
            $display("FAIL ar_outputs: got %0h expected 0",
                     {ram_we, ram_waddr, ram_wdata, ram_raddr, instr_count, rd_valid, done, overflow});
        end
        checks++;
        if ({ram_raddr_s, instr_count_s, done_s} !== 18'd0) begin
            failures++;
            $display("FAIL ar_outputs_small: got %0h expected 0", {ram_raddr_s, instr_count_s, done_s});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        base = we_cnt;
        send_byte(8'h24);
        checks++;
        if (cap_we !== 1'b0) begin failures++; $display("FAIL ar_delim_alone: got %0b expected 0", cap_we); end
        checks++;
        if ({instr_count, 8'(we_cnt - base)} !== {9'd0, 8'd0}) begin
            failures++;
            $display("FAIL ar_no_commit: got count=%0d pulses=%0d expected 0 0", instr_count, we_cnt - base);
        end
        $display("async reset: count=%0d", instr_count);
    endtask

    initial begin
        test_reset();
        test_last_wins();
        test_load4();
        test_run();
        test_step();
        test_overflow();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
